dmem_lsu: RTL and testbench

- Load/store unit on the initiator side of the data-memory interface (word-addressed array, 4-bit byte enables, clocked write, combinational read).
- Takes core load/store requests and drives dmem addr/wdata/be/wren.
- Splits word-crossing (misaligned) accesses into two word transactions.
- Returns sign/zero-extended load data, or an error, with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/dmem_lsu.sv | 163 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I funct3 codes,
// FSM states and the dmem geometry.
package lsu_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DMEM_WORDS = 2 ** (DEF_ADDR_W - 2);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP
    } lsu_state_e;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store mask/data shift into a two-word window
// and load extraction plus sign/zero extension from that same window.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic        span_o,
    output logic [7:0]  mask_o,
    output logic [63:0] sdata_o,
    output logic [31:0] rdata_o
);

    logic [2:0]  size;
    logic [2:0]  endByte;
    logic [7:0]  baseMask;
    logic [63:0] window;

    always_comb begin
        size     = 3'd4;
        baseMask = 8'h0F;
        case (funct3_i[1:0])
            2'b00:   begin size = 3'd1; baseMask = 8'h01; end
            2'b01:   begin size = 3'd2; baseMask = 8'h03; end
            default: begin size = 3'd4; baseMask = 8'h0F; end
        endcase

        endByte = {1'b0, offset_i} + size;
        span_o  = endByte > 3'd4;
        mask_o  = baseMask << offset_i;
        sdata_o = {32'b0, wdata_i} << {offset_i, 3'b000};

        window = {hi_i, lo_i} >> {offset_i, 3'b000};
        case (funct3_i)
            F3_B:    rdata_o = {{24{window[7]}}, window[7:0]};
            F3_H:    rdata_o = {{16{window[15]}}, window[15:0]};
            F3_BU:   rdata_o = {24'b0, window[7:0]};
            F3_HU:   rdata_o = {16'b0, window[15:0]};
            default: rdata_o = window[31:0];
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed dmem; splits word-crossing accesses
// into two word transactions and returns a one-cycle response pulse.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_wren,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic              mem_wren_q;

    logic        idle;
    logic [2:0]  alignF3;
    logic [1:0]  alignOff;
    logic [31:0] alignWdata;
    logic [31:0] alignHi;
    logic [31:0] alignLo;
    logic        span;
    logic [7:0]  mask;
    logic [63:0] sdata;
    logic [31:0] alignRdata;
    logic        reqError;

    // In IDLE the aligner looks at the incoming request so ACC0 lanes can be
    // registered on the accept edge; afterwards it works from the captured copy.
    assign idle       = (state_q == ST_IDLE);
    assign alignF3    = idle ? req_funct3 : funct3_q;
    assign alignOff   = idle ? req_addr[1:0] : off_q;
    assign alignWdata = idle ? req_wdata : wdata_q;
    assign alignLo    = (state_q == ST_ACC0) ? mem_rdata : lo_q;
    assign alignHi    = (state_q == ST_ACC1) ? mem_rdata : hi_q;

    lsu_align u_align (
        .funct3_i (alignF3),
        .offset_i (alignOff),
        .wdata_i  (alignWdata),
        .hi_i     (alignHi),
        .lo_i     (alignLo),
        .span_o   (span),
        .mask_o   (mask),
        .sdata_o  (sdata),
        .rdata_o  (alignRdata)
    );

    assign reqError = (req_addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W])
                   || !f3_legal(req_we, req_funct3)
                   || (span && (&req_addr[ADDR_W-1:2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b0;
            off_q       <= 2'b0;
            wdata_q     <= 32'b0;
            lo_q        <= 32'b0;
            hi_q        <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            mem_be_q    <= 4'b0;
            mem_wren_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            mem_be_q    <= 4'b0;
            mem_wren_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        wdata_q  <= req_wdata;
                        if (reqError) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= ST_ACC0;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= mask[3:0];
                            mem_wdata_q <= sdata[31:0];
                            mem_wren_q  <= req_we;
                        end
                    end
                end
                ST_ACC0: begin
                    if (!we_q) begin
                        lo_q <= mem_rdata;
                    end
                    if (span) begin
                        state_q     <= ST_ACC1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(4);
                        mem_be_q    <= mask[7:4];
                        mem_wdata_q <= sdata[63:32];
                        mem_wren_q  <= we_q;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? 32'b0 : alignRdata;
                    end
                end
                ST_ACC1: begin
                    if (!we_q) begin
                        hi_q <= mem_rdata;
                    end
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= we_q ? 32'b0 : alignRdata;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed lane/latency cases plus random traffic checked
// against a byte-addressed reference memory.
module tb_dmem_lsu;
    import lsu_pkg::*;

    localparam int AW = 11;
    localparam int MEM_BYTES = 4 * DMEM_WORDS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b0;
    logic [31:0]   req_addr = 32'b0;
    logic [31:0]   req_wdata = 32'b0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_wren;
    logic [31:0]   mem_rdata;

    logic [31:0] dmem [DMEM_WORDS];
    logic [7:0]  refMem [MEM_BYTES];
    int          wrenCount = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] accAddr [1:2];
    logic [31:0] accBe [1:2];
    logic [31:0] accWdata [1:2];
    logic [31:0] accWren [1:2];
    logic [31:0] lastRdata;

    dmem_lsu #(.BASE_ADDR(32'h0000_0000), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_wren   (mem_wren),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[AW-1:2]];

    always @(posedge clk) begin
        if (mem_wren) begin
            wrenCount <= wrenCount + 1;
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) dmem[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: treat memory as bytes and the request as n consecutive bytes.
    task automatic computeExpected(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic err,
                                   output logic [31:0] rdata, output int lat);
        int n;
        int o;
        logic legal;
        logic [31:0] v;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        o = int'(addr[1:0]);
        if (we) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
        err = (addr >= 32'(MEM_BYTES)) || !legal
           || ((o + n > 4) && (int'(addr) / 4 == DMEM_WORDS - 1));
        rdata = 32'b0;
        lat = err ? 1 : ((o + n > 4) ? 3 : 2);
        if (!err && we) begin
            for (int i = 0; i < n; i++) refMem[int'(addr) + i] = wdata[8*i +: 8];
        end else if (!err) begin
            v = 32'b0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[int'(addr) + i];
            case (f3)
                3'b000:  rdata = {{24{v[7]}}, v[7:0]};
                3'b001:  rdata = {{16{v[15]}}, v[15:0]};
                default: rdata = v;
            endcase
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        logic expErr;
        logic [31:0] expRdata;
        int expLat;
        int lat;
        int wrenStart;
        @(negedge clk);
        checkOutput("ready_idle", 32'(req_ready), 32'd1);
        checkOutput("rsp_pulse", 32'(rsp_valid), 32'd0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        computeExpected(we, f3, addr, wdata, expErr, expRdata, expLat);
        wrenStart = wrenCount;
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c <= 2) begin
                accAddr[c]  = 32'(mem_addr);
                accBe[c]    = 32'(mem_be);
                accWdata[c] = mem_wdata;
                accWren[c]  = 32'(mem_wren);
            end
            if (rsp_valid) lat = c;
            else checkOutput("busy_ready", 32'(req_ready), 32'd0);
        end
        if (lat == 0) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
        end else begin
            lastRdata = rsp_rdata;
            checkOutput("latency", 32'(lat), 32'(expLat));
            checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
            checkOutput("rsp_rdata", rsp_rdata, expRdata);
            if (expErr) checkOutput("err_nowrite", 32'(wrenCount - wrenStart), 32'd0);
        end
    endtask

    function automatic logic [31:0] refWord(input int w);
        return {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        for (int w = 0; w < DMEM_WORDS; w++) begin
            r = $urandom;
            dmem[w] = r;
            for (int b = 0; b < 4; b++) refMem[4*w + b] = r[8*b +: 8];
        end
        #12;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_wren", 32'(mem_wren), 32'd0);
        checkOutput("rst_be", 32'(mem_be), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        checkOutput("sw_addr", accAddr[1], 32'h010);
        checkOutput("sw_be", accBe[1], 32'hF);
        checkOutput("sw_wren", accWren[1], 32'd1);
        checkOutput("sw_wdata", accWdata[1], 32'hDEADBEEF);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0);
        checkOutput("lw_value", lastRdata, 32'hDEADBEEF);

        applyStimulus(1'b1, F3_W, 32'h10, 32'h11223344);
        applyStimulus(1'b1, F3_B, 32'h13, 32'h000000A5);
        checkOutput("sb_be", accBe[1], 32'h8);
        checkOutput("sb_wdata", accWdata[1], 32'hA5000000);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0);
        checkOutput("lw_merge", lastRdata, 32'hA5223344);
        applyStimulus(1'b0, F3_BU, 32'h13, 32'h0);
        checkOutput("lbu_value", lastRdata, 32'h000000A5);
        applyStimulus(1'b0, F3_B, 32'h13, 32'h0);
        checkOutput("lb_value", lastRdata, 32'hFFFFFFA5);

        applyStimulus(1'b1, F3_H, 32'h0B, 32'h0000BEEF);
        checkOutput("sh0_addr", accAddr[1], 32'h008);
        checkOutput("sh0_be", accBe[1], 32'h8);
        checkOutput("sh0_wdata", accWdata[1], 32'hEF000000);
        checkOutput("sh1_addr", accAddr[2], 32'h00C);
        checkOutput("sh1_be", accBe[2], 32'h1);
        checkOutput("sh1_wdata", accWdata[2], 32'h000000BE);
        checkOutput("sh1_wren", accWren[2], 32'd1);
        applyStimulus(1'b0, F3_H, 32'h0B, 32'h0);
        checkOutput("lh_span", lastRdata, 32'hFFFFBEEF);

        applyStimulus(1'b0, F3_W, 32'h800, 32'h0);
        applyStimulus(1'b0, F3_W, 32'h7FE, 32'h0);
        applyStimulus(1'b1, 3'b011, 32'h20, 32'h12345678);
        applyStimulus(1'b1, F3_W, 32'h7FD, 32'h12345678);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 63));
                6, 7:             a = 32'(MEM_BYTES - 16 + $urandom_range(0, 15));
                8:                a = 32'($urandom_range(0, MEM_BYTES - 1));
                default: begin
                    a = $urandom;
                    if (a < 32'(MEM_BYTES)) a = a + 32'(MEM_BYTES);
                end
            endcase
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        // Reset lands in ACC1 of a spanning word store: only the first word changes.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h22;
        req_wdata  = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rr_acc0_wren", 32'(mem_wren), 32'd1);
        @(negedge clk);
        checkOutput("rr_acc1_be", 32'(mem_be), 32'h3);
        rst_n = 1'b0;
        #1;
        checkOutput("rr_wren", 32'(mem_wren), 32'd0);
        checkOutput("rr_be", 32'(mem_be), 32'd0);
        checkOutput("rr_addr", 32'(mem_addr), 32'd0);
        checkOutput("rr_wdata", mem_wdata, 32'd0);
        checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        refMem[32'h22] = 8'h0D;
        refMem[32'h23] = 8'hF0;
        checkOutput("rr_word0", dmem[8], refWord(8));
        checkOutput("rr_word1", dmem[9], refWord(9));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, F3_W, 32'h20, 32'h0);
        applyStimulus(1'b0, F3_W, 32'h24, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
